lm_sm_sequencer: RTL and testbench
==================================

LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  in  1  single-cycle pulse; accepted only in IDLE.
REQ-004 SHALL have port: is_lm  in  1  1 = load-multiple (memory to registers), 0 = store-multiple (registers to memory); sampled with start.
REQ-005 SHALL have port: reg_list  in  8  bit i set = transfer register Ri; sampled with start.
REQ-006 SHALL have port: base_addr  in  16  first memory address; sampled with start.
REQ-007 SHALL have port: hold  in  1  memory or pipeline stall; freezes all state while high.
REQ-008 SHALL have ports: reg_rdata  in  16 (register read data) and mem_rdata  in  16 (memory read data).
REQ-009 SHALL have ports: reg_addr  out  3 (register read/write address), reg_wr_en  out  1, reg_wdata  out  16.
REQ-010 SHALL have ports: mem_addr  out  16, mem_rd_en  out  1, mem_wr_en  out  1, mem_wdata  out  16.
REQ-011 SHALL have ports: busy  out  1 (high in RUN and DONE, drives the upstream stall), done  out  1, xfer_count  out  4 (transfers completed).

Function
REQ-012 SHALL implement states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1, latch is_lm, the masked reg_list into a pending mask and base_addr into an address register, and clear xfer_count.
REQ-014 SHALL move from IDLE to RUN when the masked list is nonzero, and to DONE when it is zero (no transfers).
REQ-015 SHALL, in RUN, select the lowest set bit of the pending mask as the current register, one transfer per non-hold cycle.
REQ-016 SHALL, for SM in RUN: reg_addr=current, mem_addr=address register, mem_wdata=reg_rdata (combinational), mem_wr_en=1 and !hold.
REQ-017 SHALL, for LM in RUN: mem_addr=address register, mem_rd_en=1, reg_addr=current, reg_wdata=mem_rdata (combinational), reg_wr_en=1 and !hold.
REQ-018 SHALL, per completed transfer, clear the current bit, increment the address by 1 modulo 2^16 (0xFFFF wraps to 0x0000), and increment xfer_count.
REQ-019 SHALL go to DONE in the cycle after the transfer that clears the last pending bit.
REQ-020 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL, while hold=1, keep state, mask, address and count unchanged and drive reg_wr_en=mem_wr_en=0. mem_rd_en and the addresses stay valid.
REQ-023 SHALL drive all enables 0, reg_addr 0, mem_addr 0 and both data outputs 0 outside RUN.
REQ-024 SHALL produce N+1 cycles of busy for N set bits with no hold (N RUN cycles plus 1 DONE cycle).

Reset
REQ-025 SHALL, on reset, go to IDLE, clear the mask, address and xfer_count, and drive busy=done=0 with all enables 0, even mid-transfer.
REQ-026 SHALL give reset priority over start and hold in the same cycle.

Configuration
REQ-027 SHALL, with LMSM_R7_SKIP_EN defined, mask reg_list bit 7 at capture for both LM and SM, so R7 (PC) is never transferred and does not consume an address.
REQ-028 SHALL, without LMSM_R7_SKIP_EN, transfer bit 7 like any other bit. For LM, the register bank drops writes to address 7.

Structure
REQ-029 SHALL take the state encoding, the data width of 16 and the list width of 8 from shared package lmsm_pkg.
REQ-030 SHALL use sub-module lmsm_prio_enc8 (8-bit lowest-set-bit encoder with valid output) to select the current register.

Verification
REQ-031 SHALL cover: SM with list 0x05, base 0x0100 -> writes mem[0x0100]=R0 and mem[0x0101]=R2, done in cycle 3, xfer_count=2.
REQ-032 SHALL cover: LM with list 0x81, base 0xFFFF, macro off -> R0<=mem[0xFFFF], then reg_addr=7 at mem_addr 0x0000. With macro on -> one transfer only.
REQ-033 SHALL cover: start with list 0x00 -> DONE next cycle, done pulse, no enables, xfer_count=0.
REQ-034 SHALL cover: SM with list 0xFF and hold high for 2 cycles mid-run -> no write during hold, 8 writes to consecutive addresses, busy 11 cycles.
REQ-035 SHALL cover: reset in the 2nd RUN cycle of LM with list 0x0F -> IDLE next cycle, no further reg_wr_en, a new start accepted afterwards.
REQ-036 SHALL cover: start pulsed during RUN -> ignored, and the original transfer sequence is unchanged.

Source files
------------

// File: rtl/lmsm_pkg.sv
// Shared definitions for the load/store-multiple sequencer: state encoding and widths.
package lmsm_pkg;
    localparam int DATA_W = 16;
    localparam int LIST_W = 8;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/lmsm_prio_enc8.sv
// Lowest-set-bit encoder over the pending register mask; valid is low for an empty mask.
module lmsm_prio_enc8
    import lmsm_pkg::*;
(
    input  logic [LIST_W-1:0] req,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    // Scanning from the top down lets the lowest set bit overwrite earlier hits.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple sequencer: one register<->memory transfer per non-hold cycle.
// Optional build macro LMSM_R7_SKIP_EN removes R7 (PC) from the captured register list.
module lm_sm_sequencer
    import lmsm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_lm,
    input  logic [LIST_W-1:0] reg_list,
    input  logic [DATA_W-1:0] base_addr,
    input  logic              hold,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [IDX_W-1:0]  reg_addr,
    output logic              reg_wr_en,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  xfer_count
);

    state_e             state_q, state_d;
    logic               is_lm_q, is_lm_d;
    logic [LIST_W-1:0]  mask_q, mask_d;
    logic [DATA_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [LIST_W-1:0]  list_masked;
    logic [IDX_W-1:0]   cur_idx;
    logic               cur_valid;
    logic               in_run;
    logic               xfer;

`ifdef LMSM_R7_SKIP_EN
    assign list_masked = reg_list & 8'h7F;
`else
    assign list_masked = reg_list;
`endif

    lmsm_prio_enc8 u_prio_enc (
        .req   (mask_q),
        .idx   (cur_idx),
        .valid (cur_valid)
    );

    assign in_run = (state_q == ST_RUN) && cur_valid;
    assign xfer   = in_run && !hold;

    // Hold only freezes the transfer loop; DONE always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        is_lm_d = is_lm_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_lm_d = is_lm;
                    mask_d  = list_masked;
                    addr_d  = base_addr;
                    cnt_d   = '0;
                    state_d = (list_masked != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    mask_d  = mask_q & ~(LIST_W'(1) << cur_idx);
                    addr_d  = addr_q + DATA_W'(1);
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (mask_d == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            is_lm_q <= 1'b0;
            mask_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            is_lm_q <= is_lm_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data paths are combinational pass-throughs so a transfer completes in one cycle.
    always_comb begin
        reg_addr   = '0;
        reg_wr_en  = 1'b0;
        reg_wdata  = '0;
        mem_addr   = '0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_wdata  = '0;
        busy       = (state_q == ST_RUN) || (state_q == ST_DONE);
        done       = (state_q == ST_DONE);
        xfer_count = cnt_q;
        if (in_run) begin
            reg_addr = cur_idx;
            mem_addr = addr_q;
            if (is_lm_q) begin
                mem_rd_en = 1'b1;
                reg_wdata = mem_rdata;
                reg_wr_en = !hold;
            end else begin
                mem_wdata = reg_rdata;
                mem_wr_en = !hold;
            end
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer with a register-bank/memory environment and transfer-list model.
`timescale 1ns/1ps
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, is_lm, hold, init_env;
    logic [7:0]  reg_list;
    logic [15:0] base_addr, reg_rdata, mem_rdata;
    logic [2:0]  reg_addr;
    logic        reg_wr_en, mem_rd_en, mem_wr_en, busy, done;
    logic [15:0] reg_wdata, mem_addr, mem_wdata;
    logic [3:0]  xfer_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] regs [8];
    logic [15:0] mem  [65536];

    always #5 clk = ~clk;

    lm_sm_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_lm      (is_lm),
        .reg_list   (reg_list),
        .base_addr  (base_addr),
        .hold       (hold),
        .reg_rdata  (reg_rdata),
        .mem_rdata  (mem_rdata),
        .reg_addr   (reg_addr),
        .reg_wr_en  (reg_wr_en),
        .reg_wdata  (reg_wdata),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .xfer_count (xfer_count)
    );

    // Register bank and memory; the bank ignores writes to R7.
    assign reg_rdata = regs[reg_addr];
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (init_env) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'($urandom);
            for (int j = 0; j < 65536; j++) mem[j] <= 16'($urandom);
        end else begin
            if (reg_wr_en && reg_addr != 3'd7) regs[reg_addr] <= reg_wdata;
            if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int exp_cnt);
        chk("idle_busy_done", {busy, done}, 2'b00);
        chk("idle_enables", {reg_wr_en, mem_rd_en, mem_wr_en}, 3'b000);
        chk("idle_addrs", {reg_addr, mem_addr}, 19'h0);
        chk("idle_data", {reg_wdata, mem_wdata}, 32'h0);
        chk("idle_count", xfer_count, exp_cnt);
    endtask

    // Model: the transfer list is the set bits in ascending order; transfer k uses address base+k.
    task automatic run_txn(input bit lm, input logic [7:0] list, input logic [15:0] base,
                           input int hold_mode, input bit start_mid, input int reset_at);
        logic [7:0]  eff;
        int          idx[$];
        int          n, k, holds, busy_cycles;
        bit          h, fin, rst_hit;
        logic [15:0] rsnap [8];
        logic [15:0] a;
        eff = list;
`ifdef LMSM_R7_SKIP_EN
        eff[7] = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            if (eff[i]) idx.push_back(i);
            rsnap[i] = regs[i];
        end
        n = idx.size();
        k = 0; holds = 0; busy_cycles = 0; fin = 0; rst_hit = 0;

        @(posedge clk); #1;
        start = 1'b1; is_lm = lm; reg_list = list; base_addr = base; hold = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; is_lm = 1'($urandom); reg_list = 8'($urandom); base_addr = 16'($urandom);

        for (int t = 1; t <= 40; t++) begin
            h = 1'b0;
            if (k < n) begin
                if (hold_mode == 1) h = ($urandom % 4 == 0);
                else if (hold_mode == 2) h = (t == 3 || t == 4);
            end
            hold  = h;
            start = start_mid && (t == 2) && (k < n);
            if (start) begin
                reg_list = 8'($urandom); base_addr = 16'($urandom); is_lm = 1'($urandom);
            end
            reset = (t == reset_at);
            @(negedge clk);
            if (busy) busy_cycles++;
            if (k < n) begin
                a = base + 16'(k);
                chk("run_busy_done", {busy, done}, 2'b10);
                chk("run_reg_addr", reg_addr, idx[k]);
                chk("run_mem_addr", mem_addr, a);
                chk("run_enables", {reg_wr_en, mem_rd_en, mem_wr_en}, {lm && !h, lm, !lm && !h});
                chk("run_count", xfer_count, k);
                if (lm) chk("run_reg_wdata", reg_wdata, mem[a]);
                else    chk("run_mem_wdata", mem_wdata, rsnap[idx[k]]);
                if (t == reset_at) begin
                    rst_hit = 1;
                    break;
                end
                if (h) holds++;
                else   k++;
            end else begin
                chk("done_busy_done", {busy, done}, 2'b11);
                chk("done_enables", {reg_wr_en, mem_rd_en, mem_wr_en}, 3'b000);
                chk("done_addrs", {reg_addr, mem_addr}, 19'h0);
                chk("done_count", xfer_count, n);
                fin = 1;
                break;
            end
            @(posedge clk); #1;
        end

        if (rst_hit) begin
            @(posedge clk); #1;
            reset = 1'b0; hold = 1'b0; start = 1'b0;
            @(negedge clk);
            check_idle(0);
            repeat (3) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("post_reset_busy_wr", {busy, reg_wr_en}, 2'b00);
            end
            return;
        end

        chk("txn_finished", fin, 1);
        @(posedge clk); #1;
        hold = 1'b0; start = 1'b0;
        @(negedge clk);
        check_idle(n);
        chk("busy_cycles", busy_cycles, n + holds + 1);
        for (int j = 0; j < n; j++) begin
            a = base + 16'(j);
            if (lm) begin
                if (idx[j] != 7) chk("lm_reg_final", regs[idx[j]], mem[a]);
                else             chk("lm_r7_unchanged", regs[7], rsnap[7]);
            end else begin
                chk("sm_mem_final", mem[a], rsnap[idx[j]]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; is_lm = 1'b0; hold = 1'b0;
        reg_list = 8'h00; base_addr = 16'h0000; init_env = 1'b1;
        @(posedge clk); #1;
        init_env = 1'b0;
        @(negedge clk);
        check_idle(0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_txn(1'b0, 8'h05, 16'h0100, 0, 1'b0, 0);
        run_txn(1'b1, 8'h81, 16'hFFFF, 0, 1'b0, 0);
        run_txn(1'b0, 8'h00, 16'h1234, 0, 1'b0, 0);
        run_txn(1'b0, 8'hFF, 16'h2000, 2, 1'b0, 0);
        run_txn(1'b1, 8'h0F, 16'h3000, 0, 1'b0, 2);
        run_txn(1'b1, 8'h0F, 16'h3000, 0, 1'b0, 0);
        run_txn(1'b0, 8'h36, 16'h4000, 0, 1'b1, 0);

        // Reset wins over a simultaneous start.
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b1; is_lm = 1'b0; reg_list = 8'h0F; base_addr = 16'h5000;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check_idle(0);

        for (int r = 0; r < 12; r++) begin
            logic [15:0] b;
            b = (r % 3 == 0) ? 16'hFFFC : 16'($urandom);
            run_txn(1'($urandom), (r == 5) ? 8'h00 : 8'($urandom), b, 1, 1'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
